// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - single-port register-file writeback arbiter for ALU and load results
// Loads win over deferred ALU writes until the starvation counter forces a FIFO drain.
module writeback_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        aluValid,
  input  logic [4:0]  aluReg,
  input  logic [31:0] aluData,
  output logic        aluReady,
  input  logic        memValid,
  input  logic [4:0]  memReg,
  input  logic [31:0] memData,
  output logic        memReady,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  input  logic [4:0]  lookupReg,
  output logic        bypassHit,
  output logic [31:0] bypassData,
  output logic [1:0]  pending
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_FIFO,
    GRANT_MEM,
    GRANT_ALU
  } grant_t;

  // Entry 0 is always the FIFO head; entry 1 is only valid when pending == 2.
  logic [4:0]  fifo_reg  [0:1];
  logic [31:0] fifo_data [0:1];
  logic [1:0]  mem_streak;

  grant_t      grant;
  logic        fifo_nonempty;
  logic        starve;
  logic        alu_live;
  logic        mem_live;
  logic        pop;
  logic        push;
  logic [1:0]  pending_next;
  logic [4:0]  grant_reg;
  logic [31:0] grant_data;
  logic        tail_idx;

  always_comb begin
    fifo_nonempty = (pending != 2'd0);
    starve        = fifo_nonempty && (mem_streak == 2'd3);
    memReady      = !starve;
    aluReady      = (pending != 2'd2);
    // Requests to the zero register are handshaken but otherwise ignored.
    alu_live      = aluValid && aluReady && (aluReg != ZERO_REG);
    mem_live      = memValid && memReady && (memReg != ZERO_REG);

    grant = GRANT_NONE;
    if (starve) begin
      grant = GRANT_FIFO;
    end else if (mem_live) begin
      grant = GRANT_MEM;
    end else if (fifo_nonempty) begin
      grant = GRANT_FIFO;
    end else if (alu_live) begin
      grant = GRANT_ALU;
    end

    pop          = (grant == GRANT_FIFO);
    push         = alu_live && (grant != GRANT_ALU);
    pending_next = pending + {1'b0, push} - {1'b0, pop};

    grant_reg  = 5'd0;
    grant_data = 32'd0;
    case (grant)
      GRANT_FIFO: begin
        grant_reg  = fifo_reg[0];
        grant_data = fifo_data[0];
      end
      GRANT_MEM: begin
        grant_reg  = memReg;
        grant_data = memData;
      end
      GRANT_ALU: begin
        grant_reg  = aluReg;
        grant_data = aluData;
      end
      default: begin
        grant_reg  = 5'd0;
        grant_data = 32'd0;
      end
    endcase
  end

  // Newest value wins: FIFO tail, then head, then the write currently on the output stage.
  always_comb begin
    tail_idx   = (pending == 2'd2);
    bypassHit  = 1'b0;
    bypassData = 32'd0;
    if (lookupReg != ZERO_REG) begin
      if (fifo_nonempty && (fifo_reg[tail_idx] == lookupReg)) begin
        bypassHit  = 1'b1;
        bypassData = fifo_data[tail_idx];
      end else if (fifo_nonempty && (fifo_reg[0] == lookupReg)) begin
        bypassHit  = 1'b1;
        bypassData = fifo_data[0];
      end else if (regWrite && (writeRegister == lookupReg)) begin
        bypassHit  = 1'b1;
        bypassData = writeData;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_reg[0]   <= 5'd0;
      fifo_reg[1]   <= 5'd0;
      fifo_data[0]  <= 32'd0;
      fifo_data[1]  <= 32'd0;
      pending       <= 2'd0;
      mem_streak    <= 2'd0;
      regWrite      <= 1'b0;
      writeRegister <= 5'd0;
      writeData     <= 32'd0;
    end else begin
      pending  <= pending_next;
      regWrite <= (grant != GRANT_NONE);
      if (grant != GRANT_NONE) begin
        writeRegister <= grant_reg;
        writeData     <= grant_data;
      end

      case ({pop, push})
        2'b10: begin
          fifo_reg[0]  <= fifo_reg[1];
          fifo_data[0] <= fifo_data[1];
        end
        2'b01: begin
          if (pending == 2'd0) begin
            fifo_reg[0]  <= aluReg;
            fifo_data[0] <= aluData;
          end else begin
            fifo_reg[1]  <= aluReg;
            fifo_data[1] <= aluData;
          end
        end
        2'b11: begin
          if (pending == 2'd1) begin
            fifo_reg[0]  <= aluReg;
            fifo_data[0] <= aluData;
          end else begin
            fifo_reg[0]  <= fifo_reg[1];
            fifo_data[0] <= fifo_data[1];
            fifo_reg[1]  <= aluReg;
            fifo_data[1] <= aluData;
          end
        end
        default: begin
        end
      endcase

      if (pop || (pending_next == 2'd0)) begin
        mem_streak <= 2'd0;
      end else if ((grant == GRANT_MEM) && (mem_streak != 2'd3)) begin
        mem_streak <= mem_streak + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        aluValid = 1'b0;
  logic [4:0]  aluReg = 5'd0;
  logic [31:0] aluData = 32'd0;
  logic        aluReady;
  logic        memValid = 1'b0;
  logic [4:0]  memReg = 5'd0;
  logic [31:0] memData = 32'd0;
  logic        memReady;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  lookupReg = 5'd0;
  logic        bypassHit;
  logic [31:0] bypassData;
  logic [1:0]  pending;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  passes = 0;

  writeback_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memReg(memReg), .memData(memData), .memReady(memReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .lookupReg(lookupReg), .bypassHit(bypassHit), .bypassData(bypassData),
    .pending(pending)
  );

  always #5 clock = ~clock;

  // Every observed write must match the oldest expected write.
  always @(negedge clock) begin
    if (regWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=0x%08h, required no write", writeRegister, writeData);
      end else begin
        mon_e = exp_q.pop_front();
        if ({writeRegister, writeData} !== {mon_e.r, mon_e.d})
          $display("FAIL write_order: got r%0d=0x%08h, required r%0d=0x%08h",
                   writeRegister, writeData, mon_e.r, mon_e.d);
        else
          passes++;
      end
    end
  end

  task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    aluValid = 1'b0;
    memValid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    checks++; if (regWrite !== 1'b0) $display("FAIL reset_regWrite: got %0d, required 0", regWrite); else passes++;
    checks++; if (writeRegister !== 5'd0) $display("FAIL reset_writeRegister: got %0d, required 0", writeRegister); else passes++;
    checks++; if (writeData !== 32'd0) $display("FAIL reset_writeData: got 0x%0h, required 0", writeData); else passes++;
    checks++; if (pending !== 2'd0) $display("FAIL reset_pending: got %0d, required 0", pending); else passes++;
    checks++; if (bypassHit !== 1'b0) $display("FAIL reset_bypassHit: got %0d, required 0", bypassHit); else passes++;
    checks++; if ({aluReady, memReady} !== 2'b11) $display("FAIL reset_ready: got %b, required 11", {aluReady, memReady}); else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (regWrite !== 1'b0) $display("FAIL release_no_grant: got %0d, required 0", regWrite); else passes++;
  endtask

  task automatic test_alu_only();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd5; aluData = 32'h11;
    expect_write(5'd5, 32'h11);
    #1;
    checks++; if (aluReady !== 1'b1) $display("FAIL alu_only_ready: got %0d, required 1", aluReady); else passes++;
    @(negedge clock);
    idle();
    #1;
    checks++; if (regWrite !== 1'b1) $display("FAIL alu_only_strobe: got %0d, required 1", regWrite); else passes++;
    checks++; if (pending !== 2'd0) $display("FAIL alu_only_pending: got %0d, required 0", pending); else passes++;
    @(negedge clock);
    #1;
    checks++; if (regWrite !== 1'b0) $display("FAIL alu_only_one_cycle: got %0d, required 0", regWrite); else passes++;
    checks++; if ({writeRegister, writeData} !== {5'd5, 32'h11})
      $display("FAIL alu_only_hold: got r%0d=0x%0h, required r5=0x11", writeRegister, writeData); else passes++;
  endtask

  task automatic test_collision();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'hA;
    memValid = 1'b1; memReg = 5'd4; memData = 32'hB;
    expect_write(5'd4, 32'hB);
    expect_write(5'd3, 32'hA);
    @(negedge clock);
    idle();
    #1;
    checks++; if (pending !== 2'd1) $display("FAIL collision_pending1: got %0d, required 1", pending); else passes++;
    @(negedge clock);
    #1;
    checks++; if (pending !== 2'd0) $display("FAIL collision_pending0: got %0d, required 0", pending); else passes++;
    @(negedge clock);
  endtask

  task automatic test_backpressure();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd1; aluData = 32'h201;
    memValid = 1'b1; memReg = 5'd10; memData = 32'h110;
    expect_write(5'd10, 32'h110);
    @(negedge clock);
    aluReg = 5'd2; aluData = 32'h202;
    memReg = 5'd11; memData = 32'h111;
    expect_write(5'd11, 32'h111);
    #1;
    checks++; if (pending !== 2'd1) $display("FAIL fill_pending1: got %0d, required 1", pending); else passes++;
    @(negedge clock);
    aluReg = 5'd6; aluData = 32'h206;
    memReg = 5'd12; memData = 32'h112;
    expect_write(5'd12, 32'h112);
    #1;
    checks++; if (pending !== 2'd2) $display("FAIL fill_pending2: got %0d, required 2", pending); else passes++;
    checks++; if (aluReady !== 1'b0) $display("FAIL fill_aluReady_low: got %0d, required 0", aluReady); else passes++;
    @(negedge clock);
    memReg = 5'd13; memData = 32'h113;
    expect_write(5'd1, 32'h201);
    #1;
    checks++; if (memReady !== 1'b0) $display("FAIL starve_memReady_low: got %0d, required 0", memReady); else passes++;
    checks++; if (aluReady !== 1'b0) $display("FAIL starve_aluReady: got %0d, required 0", aluReady); else passes++;
    @(negedge clock);
    expect_write(5'd13, 32'h113);
    #1;
    checks++; if (memReady !== 1'b1) $display("FAIL starve_memReady_back: got %0d, required 1", memReady); else passes++;
    checks++; if (aluReady !== 1'b1) $display("FAIL starve_aluReady_back: got %0d, required 1", aluReady); else passes++;
    checks++; if (pending !== 2'd1) $display("FAIL starve_pending: got %0d, required 1", pending); else passes++;
    @(negedge clock);
    idle();
    expect_write(5'd2, 32'h202);
    #1;
    checks++; if (pending !== 2'd2) $display("FAIL drain_pending2: got %0d, required 2", pending); else passes++;
    @(negedge clock);
    expect_write(5'd6, 32'h206);
    #1;
    checks++; if (pending !== 2'd1) $display("FAIL drain_pending1: got %0d, required 1", pending); else passes++;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (pending !== 2'd0) $display("FAIL drain_pending0: got %0d, required 0", pending); else passes++;
  endtask

  task automatic test_bypass();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd7; aluData = 32'h1;
    memValid = 1'b1; memReg = 5'd20; memData = 32'h120;
    expect_write(5'd20, 32'h120);
    @(negedge clock);
    aluData = 32'h2;
    memReg = 5'd21; memData = 32'h121;
    expect_write(5'd21, 32'h121);
    @(negedge clock);
    idle();
    lookupReg = 5'd7;
    expect_write(5'd7, 32'h1);
    #1;
    checks++; if (pending !== 2'd2) $display("FAIL bypass_pending: got %0d, required 2", pending); else passes++;
    checks++; if ({bypassHit, bypassData} !== {1'b1, 32'h2})
      $display("FAIL bypass_tail: got hit=%0d data=0x%0h, required hit=1 data=0x2", bypassHit, bypassData); else passes++;
    lookupReg = 5'd31;
    #1;
    checks++; if ({bypassHit, bypassData} !== {1'b0, 32'h0})
      $display("FAIL bypass_zero_reg: got hit=%0d data=0x%0h, required hit=0 data=0x0", bypassHit, bypassData); else passes++;
    lookupReg = 5'd9;
    #1;
    checks++; if ({bypassHit, bypassData} !== {1'b0, 32'h0})
      $display("FAIL bypass_miss: got hit=%0d data=0x%0h, required hit=0 data=0x0", bypassHit, bypassData); else passes++;
    @(negedge clock);
    lookupReg = 5'd7;
    expect_write(5'd7, 32'h2);
    #1;
    checks++; if ({bypassHit, bypassData} !== {1'b1, 32'h2})
      $display("FAIL bypass_over_output: got hit=%0d data=0x%0h, required hit=1 data=0x2", bypassHit, bypassData); else passes++;
    @(negedge clock);
    #1;
    checks++; if ({pending, bypassHit, bypassData} !== {2'd0, 1'b1, 32'h2})
      $display("FAIL bypass_output_stage: got pending=%0d hit=%0d data=0x%0h, required pending=0 hit=1 data=0x2",
               pending, bypassHit, bypassData); else passes++;
    @(negedge clock);
    #1;
    checks++; if (bypassHit !== 1'b0) $display("FAIL bypass_expired: got %0d, required 0", bypassHit); else passes++;
    lookupReg = 5'd0;
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd31; aluData = 32'hDEAD;
    #1;
    checks++; if (aluReady !== 1'b1) $display("FAIL zero_aluReady: got %0d, required 1", aluReady); else passes++;
    @(negedge clock);
    idle();
    #1;
    checks++; if (regWrite !== 1'b0) $display("FAIL zero_no_write: got %0d, required 0", regWrite); else passes++;
    checks++; if (pending !== 2'd0) $display("FAIL zero_pending: got %0d, required 0", pending); else passes++;
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd31; aluData = 32'hBEEF;
    memValid = 1'b1; memReg = 5'd8; memData = 32'h88;
    expect_write(5'd8, 32'h88);
    @(negedge clock);
    idle();
    #1;
    checks++; if (pending !== 2'd0) $display("FAIL zero_with_load_pending: got %0d, required 0", pending); else passes++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      aluValid = 1'b1; aluReg = 5'(i + 1); aluData = 32'h300 + 32'(i);
      expect_write(5'(i + 1), 32'h300 + 32'(i));
      #1;
      checks++; if (pending !== 2'd0) $display("FAIL b2b_pending_%0d: got %0d, required 0", i, pending); else passes++;
    end
    @(negedge clock);
    idle();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    aluValid = 1'b1; aluReg = 5'd1; aluData = 32'h401;
    memValid = 1'b1; memReg = 5'd22; memData = 32'h122;
    expect_write(5'd22, 32'h122);
    @(negedge clock);
    aluReg = 5'd2; aluData = 32'h402;
    memReg = 5'd23; memData = 32'h123;
    expect_write(5'd23, 32'h123);
    @(negedge clock);
    idle();
    lookupReg = 5'd1;
    #1;
    checks++; if (pending !== 2'd2) $display("FAIL rst_mid_prefill: got %0d, required 2", pending); else passes++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pending !== 2'd0) $display("FAIL rst_mid_pending: got %0d, required 0", pending); else passes++;
    checks++; if (regWrite !== 1'b0) $display("FAIL rst_mid_regWrite: got %0d, required 0", regWrite); else passes++;
    checks++; if (bypassHit !== 1'b0) $display("FAIL rst_mid_bypass: got %0d, required 0", bypassHit); else passes++;
    checks++; if ({aluReady, memReady} !== 2'b11) $display("FAIL rst_mid_ready: got %b, required 11", {aluReady, memReady}); else passes++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      checks++; if ({regWrite, pending} !== 3'b000)
        $display("FAIL rst_mid_after_%0d: got regWrite=%0d pending=%0d, required 0 0", i, regWrite, pending); else passes++;
    end
    lookupReg = 5'd0;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_backpressure();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drained: got %0d outstanding, required 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
